fir_frame_buffer: RTL

- Sits directly downstream of the FIR stage and upstream of the FFT stage.
- Collects the FIR output sample stream (fir_d qualified by fir_valid) into fixed-length frames.
- Uses two ping-pong banks, so one frame can be filled while the previous one is held for the FFT.
- Presents each completed frame in parallel with a valid/ready handshake.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/frame_bank.sv | 39 +++
 rtl/fir_frame_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, types and helpers for the FIR-to-FFT framing path
//
// Contents:
//   DATA_W_DEF / FRAME_LEN_DEF : default sample width and frame length
//   FRAME_LOG2                 : index width of the default frame
//   rd_state_t                 : read-side FSM states (EMPTY, PRESENT)
//   bitrev()                   : reverse the low nbits of an index (FFT input order)
package fft_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int FRAME_LEN_DEF = 16;
  localparam int FRAME_LOG2    = $clog2(FRAME_LEN_DEF);

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } rd_state_t;

  // nbits is normally FRAME_LOG2; it is an argument so a non-default
  // FRAME_LEN on the top level reorders over its own index width.
  function automatic int bitrev(input int idx, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < nbits; i++) begin
      r = (r << 1) | ((idx >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// rtl/frame_bank.sv - one FRAME_LEN x DATA_W sample bank with a full flag
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears data and full)
//   wr_en      : store wr_data at slot wr_idx
//   wr_idx     : slot index of the write
//   wr_data    : sample to store
//   set_full   : mark the bank full
//   clr_full   : mark the bank empty (wins over set_full)
//   full       : bank holds a complete frame
//   data       : whole bank, slot k at bits [k*DATA_W +: DATA_W]
module frame_bank #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 16,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          set_full,
  input  logic                          clr_full,
  output logic                          full,
  output logic [DATA_W*FRAME_LEN-1:0]   data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) data[wr_idx*DATA_W +: DATA_W] <= wr_data;
      if (clr_full)      full <= 1'b0;
      else if (set_full) full <= 1'b1;
    end
  end

endmodule

// File: rtl/fir_frame_buffer.sv
// rtl/fir_frame_buffer.sv - ping-pong framer between the FIR and FFT stages
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   fir_valid   : FIR sample strobe
//   fir_d       : FIR sample, stored verbatim
//   frame_ready : FFT accepts the presented frame
//   frame_valid : a complete frame is presented
//   frame_data  : presented frame, slot k at bits [k*DATA_W +: DATA_W]
//   overflow    : sticky, a sample arrived while the write bank was full
//
// Build option: FRAME_BITREV_EN presents slot k = sample bitrev(k)
// (decimation-in-time order); storage order is unaffected.
module fir_frame_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fir_valid,
  input  logic [DATA_W-1:0]             fir_d,
  input  logic                          frame_ready,
  output logic                          frame_valid,
  output logic [DATA_W*FRAME_LEN-1:0]   frame_data,
  output logic                          overflow
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int FW    = DATA_W * FRAME_LEN;

  rd_state_t        state;
  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_cnt;
  logic [1:0]       full, wr_en, set_full, clr_full, full_nxt;
  logic [FW-1:0]    bank0_data, bank1_data, bank0_nxt, bank1_nxt;
  logic [FW-1:0]    rd_img, oth_img;
  logic             hs, wr_blocked, wr_ok, wr_last;

  // Bank image as it will be after this edge's write, so a frame can be
  // presented in the cycle right after its last sample lands.
  function automatic logic [FW-1:0] merge(input logic [FW-1:0] img, input logic en,
                                          input logic [IDX_W-1:0] idx,
                                          input logic [DATA_W-1:0] d);
    logic [FW-1:0] r;
    r = img;
    if (en) r[idx*DATA_W +: DATA_W] = d;
    return r;
  endfunction

  function automatic logic [FW-1:0] slot_order(input logic [FW-1:0] img);
    logic [FW-1:0] r;
`ifdef FRAME_BITREV_EN
    r = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      r[k*DATA_W +: DATA_W] = img[bitrev(k, IDX_W)*DATA_W +: DATA_W];
    end
`else
    r = img;
`endif
    return r;
  endfunction

  assign hs          = frame_valid & frame_ready;
  assign clr_full[0] = hs & ~rd_bank;
  assign clr_full[1] = hs &  rd_bank;

  // A bank freed by the reader this cycle is writable this cycle.
  assign wr_blocked  = full[wr_bank] & ~clr_full[wr_bank];
  assign wr_ok       = fir_valid & ~wr_blocked;
  assign wr_last     = (wr_cnt == IDX_W'(FRAME_LEN - 1));
  assign wr_en[0]    = wr_ok & ~wr_bank;
  assign wr_en[1]    = wr_ok &  wr_bank;
  assign set_full    = wr_en & {2{wr_last}};
  assign full_nxt    = (full & ~clr_full) | set_full;

  assign bank0_nxt   = merge(bank0_data, wr_en[0], wr_cnt, fir_d);
  assign bank1_nxt   = merge(bank1_data, wr_en[1], wr_cnt, fir_d);
  assign rd_img      = rd_bank ? bank1_nxt : bank0_nxt;
  assign oth_img     = rd_bank ? bank0_nxt : bank1_nxt;

  frame_bank #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) u_bank0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_idx(wr_cnt), .wr_data(fir_d),
    .set_full(set_full[0]), .clr_full(clr_full[0]), .full(full[0]), .data(bank0_data)
  );

  frame_bank #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) u_bank1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_idx(wr_cnt), .wr_data(fir_d),
    .set_full(set_full[1]), .clr_full(clr_full[1]), .full(full[1]), .data(bank1_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
      if (fir_valid && wr_blocked) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      rd_bank     <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (full_nxt[rd_bank]) begin
            state       <= PRESENT;
            frame_valid <= 1'b1;
            frame_data  <= slot_order(rd_img);
          end
        end
        PRESENT: begin
          if (frame_ready) begin
            rd_bank <= ~rd_bank;
            if (full_nxt[~rd_bank]) begin
              frame_data  <= slot_order(oth_img);
            end else begin
              state       <= EMPTY;
              frame_valid <= 1'b0;
            end
          end
        end
        default: begin
          state       <= EMPTY;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
